// File: rtl/adc_scan_sequencer.sv
// Scans a multi-channel ADC through a 16-bit SPI master: one transaction per enabled channel per tick.
// Latency: tick at cycle T -> SPI_ENA high at T+2; result strobe one cycle after the capture cycle.
// No downstream backpressure: RESULT_VALID is a one-cycle strobe; SPI pacing comes from FIN.
//
// Ports: SYS_CLK/RST (async, active high); RUN enables the period timer; CH_MASK selects channels
// (sampled at scan start); CLR_ERR clears sticky errors; SPI_ENA/SPI_DATA_MOSI/SPI_FIN/SPI_DATA_MISO
// talk to the SPI master; RESULT_DATA/RESULT_CH/RESULT_VALID carry samples; BUSY, OVERRUN, TIMEOUT_ERR
// report status.
// Optional macro SEQ_AVG4_EN: each channel is sampled 4 times and the truncated mean is reported.
module adc_scan_sequencer #(
  parameter int          NUM_CH      = 8,
  parameter int          SAMPLE_DIV  = 1000,
  parameter logic [15:0] CMD_BASE    = 16'h8000,
  parameter int          SETTLE_CYC  = 4,
  parameter int          GAP_CYC     = 4,
  parameter int          TIMEOUT_CYC = 64
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic [NUM_CH-1:0] CH_MASK,
  input  logic              CLR_ERR,
  output logic              SPI_ENA,
  output logic [15:0]       SPI_DATA_MOSI,
  input  logic              SPI_FIN,
  input  logic [15:0]       SPI_DATA_MISO,
  output logic [15:0]       RESULT_DATA,
  output logic [2:0]        RESULT_CH,
  output logic              RESULT_VALID,
  output logic              BUSY,
  output logic              OVERRUN,
  output logic              TIMEOUT_ERR
);

  localparam int PW   = $clog2(SAMPLE_DIV);
  localparam int MAXC = (TIMEOUT_CYC > SETTLE_CYC) ?
                        ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) :
                        ((SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [PW-1:0] PER_LAST    = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, XFER, SETTLE, CAPTURE, GAP} state_t;

  state_t              state_q;
  logic [PW-1:0]       per_q, per_d;
  logic                tick;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          ch_q;
  logic [NUM_CH-1:0]   rem_q;
  logic                ena_q, busy_q, ovr_q, tmo_q, res_vld_q;
  logic [15:0]         mosi_q, res_dat_q;
  logic [2:0]          res_ch_q;

  // Channel picker: from CH_MASK when starting a scan, else from the channels still pending.
  logic [NUM_CH-1:0]   pick_src, pick_rest;
  logic [2:0]          pick_ch;

`ifdef SEQ_AVG4_EN
  logic [1:0]  samp_q;
  logic [17:0] acc_q, sum;
  logic        skip_q;   // a sample of the current channel timed out
  assign sum = acc_q + {2'b00, SPI_DATA_MISO};
`endif

  function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  always_comb begin
    pick_src  = (state_q == IDLE) ? CH_MASK : rem_q;
    pick_ch   = lowest(pick_src);
    pick_rest = pick_src & ~(NUM_CH'(1) << pick_ch);
  end

  // Period timer: held at 0 while RUN is low, one-cycle tick at wrap.
  always_comb begin
    per_d = per_q;
    tick  = 1'b0;
    if (!RUN) begin
      per_d = '0;
    end else if (per_q == PER_LAST) begin
      per_d = '0;
      tick  = 1'b1;
    end else begin
      per_d = per_q + 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      per_q     <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
      rem_q     <= '0;
      ena_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
      res_vld_q <= 1'b0;
      mosi_q    <= '0;
      res_dat_q <= '0;
      res_ch_q  <= '0;
`ifdef SEQ_AVG4_EN
      samp_q    <= '0;
      acc_q     <= '0;
      skip_q    <= 1'b0;
`endif
    end else begin
      per_q     <= per_d;
      res_vld_q <= 1'b0;
      // Clears first so a same-cycle error event (assigned later) wins.
      if (CLR_ERR) begin
        ovr_q <= 1'b0;
        tmo_q <= 1'b0;
      end
      if (tick && state_q != IDLE) ovr_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (tick && CH_MASK != '0) begin
            ch_q    <= pick_ch;
            rem_q   <= pick_rest;
            mosi_q  <= CMD_BASE | (16'(pick_ch) << 10);
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          // MOSI word was loaded one cycle ahead so the master sees it before ENA.
          ena_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= XFER;
        end
        XFER: begin
          if (SPI_FIN) begin
            cnt_q   <= '0;
            state_q <= SETTLE;
          end else if (cnt_q == TMO_LAST) begin
            tmo_q   <= 1'b1;
            ena_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQ_AVG4_EN
            skip_q  <= 1'b1;
`endif
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
`ifdef SEQ_AVG4_EN
          samp_q <= samp_q + 2'd1;
          if (samp_q == 2'd3) begin
            res_dat_q <= sum[17:2];
            res_ch_q  <= ch_q;
            res_vld_q <= 1'b1;
            acc_q     <= '0;
          end else begin
            acc_q <= sum;
          end
`else
          res_dat_q <= SPI_DATA_MISO;
          res_ch_q  <= ch_q;
          res_vld_q <= 1'b1;
`endif
          ena_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= GAP;
        end
        GAP: begin
          if (cnt_q != GAP_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
`ifdef SEQ_AVG4_EN
            if (samp_q != 2'd0 && !skip_q) begin
              // More samples of the same channel; MOSI word is unchanged.
              state_q <= START;
            end else begin
              samp_q <= '0;
              acc_q  <= '0;
              skip_q <= 1'b0;
`endif
              if (rem_q != '0) begin
                ch_q    <= pick_ch;
                rem_q   <= pick_rest;
                mosi_q  <= CMD_BASE | (16'(pick_ch) << 10);
                state_q <= START;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
`ifdef SEQ_AVG4_EN
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SPI_ENA       = ena_q;
  assign SPI_DATA_MOSI = mosi_q;
  assign RESULT_DATA   = res_dat_q;
  assign RESULT_CH     = res_ch_q;
  assign RESULT_VALID  = res_vld_q;
  assign BUSY          = busy_q;
  assign OVERRUN       = ovr_q;
  assign TIMEOUT_ERR   = tmo_q;

endmodule
